step_controller: RTL
====================

Name: step_controller

Overview:
Hardware initiator for the bilinear core's four-phase STEP/STEP_ACK stepping handshake. It replaces bench-driven stepping so a host register interface can request N steps, or run until the core reports done. It sits between the control/status register block and bilinear_core_scalar, driving step and watching step_ack and done. It also counts completed steps and flags a hung responder with a watchdog.

Parameters:
CNT_W, 32, width of the step request and completed-step counters
TO_W, 16, width of the per-phase watchdog counter
TO_MAX, 16'd1000, cycles allowed in one handshake phase before timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  host presents a command
cmd_ready  out  1  controller can accept a command (high only in IDLE/ERR)
cmd_nsteps  in  CNT_W  number of steps requested (ignored if cmd_run_all)
cmd_run_all  in  1  1 = step until core_done, no count limit
abort  in  1  stop after the in-flight handshake completes
core_done  in  1  done flag from core
step  out  1  step request to core
step_ack  in  1  step acknowledge from core
busy  out  1  command in progress
cmd_done  out  1  one-cycle pulse when a command ends (normal, core_done or abort)
timeout_err  out  1  sticky watchdog error
steps_total  out  CNT_W  handshakes completed since reset, saturating at all-ones

Behaviour:
- Reset values (rst_n=0 at an edge): state=IDLE, step=0, busy=0, cmd_done=0, timeout_err=0, steps_total=0, remaining=0, watchdog=0, abort_pend=0. cmd_ready=1 after reset.
- All outputs are registered.
- States: IDLE, REQ, REL, FIN, ERR.
- IDLE:
  - cmd_ready=1.
  - On edge with cmd_valid&cmd_ready, latch remaining=cmd_nsteps and run_all=cmd_run_all.
  - If core_done=1, or (!cmd_run_all and cmd_nsteps==0), go to FIN.
  - Otherwise go to REQ, with step=1 and busy=1 from the next cycle (1-cycle latency from accept to step).
- REQ: step held 1.
  - On an edge sampling step_ack=1, go to REL; step=0 the next cycle.
- REL: step held 0.
  - On an edge sampling step_ack=0, the handshake completes: steps_total+=1 (saturating), and remaining-=1 if !run_all.
  - Then go to FIN if abort_pend, or core_done, or (!run_all and remaining becomes 0). Otherwise go to REQ.
- Back-to-back steps: step rises at the earliest 1 cycle after ack low is sampled.
- FIN: cmd_done=1 for exactly one cycle, busy=0, then IDLE.
- abort: sampled in any state.
  - In REQ/REL it sets abort_pend.
  - step is never dropped mid-REQ; the in-flight handshake always completes, then the controller goes to FIN.
  - In IDLE, abort is ignored; abort_pend is cleared on entry to IDLE.
- core_done rising while in REQ has no immediate effect; it is checked at REL completion.
- Watchdog:
  - Counts cycles in REQ or REL and clears on every state change.
  - On reaching TO_MAX, go to ERR with timeout_err=1, step=0, busy=0, cmd_done pulsed once.
  - ERR: cmd_ready=1. A new accepted command clears timeout_err and proceeds as from IDLE. Only a new command or reset leaves ERR.
- cmd_valid while busy: cmd_ready=0, so the command is not consumed and no state changes.
- Reset mid-operation: step=0 at the next edge regardless of step_ack, and steps_total clears.
- Widths: remaining and steps_total are unsigned CNT_W. remaining never underflows because a count of 0 is filtered at accept.

Test Plan:
- Accept nsteps=5, responder acks 1 cycle after step and releases 1 cycle after step falls -> exactly 5 step pulses, steps_total=5, one cmd_done pulse, busy low afterwards.
- nsteps=0, run_all=0 -> no step rise, cmd_done pulses 2 cycles after accept, steps_total unchanged.
- run_all=1, core_done asserted during the 7th REQ -> 7 handshakes complete, then cmd_done, steps_total=7.
- TO_MAX=16, step_ack stuck 0 -> step high 16 cycles, then step=0 and timeout_err=1. A new command with nsteps=1 clears timeout_err and completes 1 step.
- abort pulsed in REQ of step 3 of 10 with ack delayed 4 cycles -> step 3 completes, steps_total=3, cmd_done, no step 4.
- rst_n=0 for one edge while in REQ with ack=1 -> step=0, busy=0, steps_total=0, cmd_ready=1 the next cycle. A cmd_valid while busy is not accepted.

Source files
------------

// File: rtl/step_controller.sv
// Initiator for the core's four-phase STEP/STEP_ACK handshake: runs N steps or
// until core_done, counts completed handshakes and watches for a hung responder.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// REQ   | step high, waiting for step_ack to rise
// REL   | step low, waiting for step_ack to fall (handshake completes)
// FIN   | command finished, cmd_done pulses on the way back to IDLE
// ERR   | watchdog expired, timeout_err sticky until a new command
module step_controller #(
  parameter int unsigned       CNT_W  = 32,
  parameter int unsigned       TO_W   = 16,
  parameter logic [TO_W-1:0]   TO_MAX = 16'd1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_nsteps,
  input  logic             cmd_run_all,
  input  logic             abort,
  input  logic             core_done,
  output logic             step,
  input  logic             step_ack,
  output logic             busy,
  output logic             cmd_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] steps_total
);

  typedef enum logic [2:0] {IDLE, REQ, REL, FIN, ERR} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d, rem_next;
  logic [CNT_W-1:0] total_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             run_all_q, run_all_d;
  logic             abort_pend_q, abort_pend_d;
  logic             step_d, busy_d, cmd_done_d, cmd_ready_d, err_d;
  logic             accept;

  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    run_all_d    = run_all_q;
    abort_pend_d = abort_pend_q;
    total_d      = steps_total;
    err_d        = timeout_err;
    wd_d         = '0;
    cmd_done_d   = 1'b0;
    rem_next     = remaining_q;

    case (state_q)
      IDLE, ERR: begin
        abort_pend_d = 1'b0;
        if (accept) begin
          remaining_d = cmd_nsteps;
          run_all_d   = cmd_run_all;
          err_d       = 1'b0;
          if (core_done || (!cmd_run_all && cmd_nsteps == '0)) state_d = FIN;
          else                                                  state_d = REQ;
        end
      end
      REQ, REL: begin
        if (abort) abort_pend_d = 1'b1;
        if (state_q == REQ && step_ack) begin
          state_d = REL;
        end else if (state_q == REL && !step_ack) begin
          total_d     = (&steps_total) ? steps_total : steps_total + 1'b1;
          rem_next    = run_all_q ? remaining_q : remaining_q - 1'b1;
          remaining_d = rem_next;
          if (abort_pend_q || abort || core_done || (!run_all_q && rem_next == '0))
            state_d = FIN;
          else
            state_d = REQ;
        end else if (wd_q == TO_MAX - 1'b1) begin
          // Watchdog fires only when the phase would otherwise continue.
          state_d    = ERR;
          err_d      = 1'b1;
          cmd_done_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      FIN: begin
        state_d      = IDLE;
        cmd_done_d   = 1'b1;
        abort_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    step_d      = (state_d == REQ);
    busy_d      = (state_d == REQ) || (state_d == REL);
    cmd_ready_d = (state_d == IDLE) || (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      run_all_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      wd_q         <= '0;
      step         <= 1'b0;
      busy         <= 1'b0;
      cmd_done     <= 1'b0;
      cmd_ready    <= 1'b1;
      timeout_err  <= 1'b0;
      steps_total  <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      run_all_q    <= run_all_d;
      abort_pend_q <= abort_pend_d;
      wd_q         <= wd_d;
      step         <= step_d;
      busy         <= busy_d;
      cmd_done     <= cmd_done_d;
      cmd_ready    <= cmd_ready_d;
      timeout_err  <= err_d;
      steps_total  <= total_d;
    end
  end

endmodule
